instr_encoder: RTL and testbench
================================

Name: instr_encoder

Overview:
- Inverse of the RV64I instruction decoder: packs opcode, funct and register fields plus a 64-bit immediate into 32-bit raw instruction words.
- Expands the `li rd, imm64` pseudo-instruction into a multi-instruction sequence.
- Used by self-test and boot-stub generation to feed the fetch/IMEM path.
- Request side and instruction side are independent valid/ready handshakes.

Parameters:
NOP_WORD, 32'h0000_0013, word emitted for unsupported opcodes and for `li` to x0

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  encoder can accept a request
req_li  in  1  1 = `li rd, imm` pseudo; opcode/funct fields ignored
req_opcode  in  7  RV64I opcode (LUI, AUIPC, JAL, JALR, B, L, S, RI, RIW, R, RW)
req_funct3  in  3  funct3
req_funct7  in  7  funct7; for RI shifts only bits [6:1] are used
req_rd  in  5  destination register
req_rs1  in  5  source register 1
req_rs2  in  5  source register 2
req_imm  in  64  immediate (byte offset for B/J; U uses imm[31:12])
instr_valid  out  1  instr_data valid
instr_ready  in  1  consumer accepts word
instr_data  out  32  encoded instruction
instr_last  out  1  final word of the current request

Behaviour:
- Reset values: req_ready=1, instr_valid=0, instr_data=0, instr_last=0; FSM goes to IDLE. Reset mid-sequence abandons the sequence; no further words are emitted.
- Request handshake:
  - req_ready = (state==IDLE).
  - A request is accepted on req_valid&&req_ready and all fields are latched.
  - The first word is registered: instr_valid rises the cycle after acceptance.
- Instruction handshake:
  - instr_data and instr_last hold stable while instr_valid && !instr_ready.
  - On acceptance, the next word of the sequence is presented the following cycle with no bubble.
  - After the last word is accepted, the FSM returns to IDLE and req_ready=1 the following cycle.
  - A new request cannot overlap the draining of a previous one.
- Single-instruction encoding by req_opcode:
  - R/RW: R-type.
  - L/RI/RIW/JALR: I-type.
  - RI with funct3 001/101: [31:26]=funct7[6:1], [25:20]=imm[5:0].
  - RIW with funct3 001/101: [31:25]=funct7, [24:20]=imm[4:0].
  - S: S-type imm[11:0].
  - B: B-type imm[12:1].
  - LUI/AUIPC: imm[31:12].
  - JAL: J-type imm[20:1].
  - Other opcodes: NOP_WORD.
  - Immediates are truncated to field width without range checking.
  - instr_last=1 on the single word.
- LI expansion (signed imm = v):
  - rd==0: one NOP_WORD.
  - −2048 ≤ v ≤ 2047: `addi rd,x0,v[11:0]`.
  - −2^31 ≤ v < 2^31:
    - hi = (v[31:0]+32'h800)>>12, 20 bits, computed with 32-bit wrap.
    - lo = v[11:0].
    - Emit `lui rd,hi`, then `addiw rd,rd,lo` only if lo≠0.
  - Otherwise:
    - Load u = v[63:32] (sign-extended, 32-bit) into rd using the rule above.
    - Then emit, always and in order: `slli rd,rd,11`; `addi rd,rd,{1'b0,v[31:21]}`; `slli 11`; `addi {1'b0,v[20:10]}`; `slli 10`; `addi {2'b0,v[9:0]}`.
    - Zero chunks are still emitted.
    - Maximum 8 words.
- FSM states: IDLE, SINGLE, LI_HI (lui or addi), LI_LO (addiw), SH1, AD1, SH2, AD2, SH3, AD3.
  - Each state advances only on instr_ready.
  - Skipped states (lo==0, no 64-bit tail) are bypassed directly.
  - instr_last is asserted on the terminal state.

Test Plan:
- `li x5,42` → exactly one word 0x02A00293 with instr_last=1; req_ready back to 1 one cycle after acceptance.
- `li x10,0x12345678` → 0x12345537, then 0x6785051B (last).
- `li x10,0x7FFFFFFF` → `lui x10,0x80000` 0x80000537, then `addiw x10,x10,-1` 0xFFF5051B.
- `li x1,0x0000000100000000` → 0x00100093, 0x00B09093, 0x00008093, 0x00B09093, 0x00008093, 0x00A09093, 0x00008093 (7 words, last on 7th); instr_ready tied high, so seven consecutive valid cycles.
- `add x3,x1,x2` → 0x002081B3; `beq x1,x2,-4` → 0xFE208EE3; unknown opcode 7'h7F → 0x00000013. Hold instr_ready=0 for 3 cycles: data stable and req_ready=0 throughout.
- `li` with a 64-bit immediate, reset asserted after the 3rd word → next cycle instr_valid=0, req_ready=1; a new `li x5,42` then yields only 0x02A00293.

Source files
------------

// File: rtl/instr_encoder.sv
// instr_encoder: packs RV64I fields into 32-bit instruction words and expands
// the `li rd, imm64` pseudo-instruction into a lui/addi/addiw/slli sequence.
// Requests are latched on acceptance; words are driven from the latched
// fields and the FSM state, so outputs stay stable while the consumer stalls.
module instr_encoder #(
  parameter logic [31:0] NOP_WORD = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_li,
  input  logic [6:0]  req_opcode,
  input  logic [2:0]  req_funct3,
  input  logic [6:0]  req_funct7,
  input  logic [4:0]  req_rd,
  input  logic [4:0]  req_rs1,
  input  logic [4:0]  req_rs2,
  input  logic [63:0] req_imm,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr_data,
  output logic        instr_last
);

  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_B     = 7'b1100011;
  localparam logic [6:0] OP_L     = 7'b0000011;
  localparam logic [6:0] OP_S     = 7'b0100011;
  localparam logic [6:0] OP_RI    = 7'b0010011;
  localparam logic [6:0] OP_RIW   = 7'b0011011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_RW    = 7'b0111011;

  typedef enum logic [3:0] {
    IDLE, SINGLE, LI_HI, LI_LO, SH1, AD1, SH2, AD2, SH3, AD3
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic        r_li;
  logic [6:0]  r_opcode;
  logic [2:0]  r_funct3;
  logic [6:0]  r_funct7;
  logic [4:0]  r_rd;
  logic [4:0]  r_rs1;
  logic [4:0]  r_rs2;
  logic [63:0] r_imm;

  logic        w_fits32;
  logic [31:0] w_u32;
  logic        w_u_small;
  logic [19:0] w_hi;
  logic [11:0] w_lo;
  logic        w_need_lo;
  logic        w_shift_f3;
  logic [31:0] w_single;
  logic [31:0] w_data;
  logic        w_last;

  // The 32-bit value loaded first: the whole immediate when it fits in 32
  // signed bits, otherwise its upper half (the low half follows in chunks).
  assign w_fits32  = (r_imm[63:31] == {33{r_imm[31]}});
  assign w_u32     = w_fits32 ? r_imm[31:0] : r_imm[63:32];
  assign w_u_small = (w_u32[31:11] == {21{w_u32[11]}});
  // Adding 0x800 before taking [31:12] only carries when bit 11 is set.
  assign w_hi      = w_u32[31:12] + {19'd0, w_u32[11]};
  assign w_lo      = w_u32[11:0];
  assign w_need_lo = !w_u_small && (w_lo != 12'd0);
  assign w_shift_f3 = (r_funct3 == 3'b001) || (r_funct3 == 3'b101);

  // State register; reset abandons any sequence in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Capture all request fields on the request handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_li     <= 1'b0;
      r_opcode <= 7'd0;
      r_funct3 <= 3'd0;
      r_funct7 <= 7'd0;
      r_rd     <= 5'd0;
      r_rs1    <= 5'd0;
      r_rs2    <= 5'd0;
      r_imm    <= 64'd0;
    end else if (req_valid && req_ready) begin
      r_li     <= req_li;
      r_opcode <= req_opcode;
      r_funct3 <= req_funct3;
      r_funct7 <= req_funct7;
      r_rd     <= req_rd;
      r_rs1    <= req_rs1;
      r_rs2    <= req_rs2;
      r_imm    <= req_imm;
    end
  end

  // Single-word encoding selected by opcode; li to x0 also lands here as a NOP.
  always_comb begin
    w_single = NOP_WORD;
    if (!r_li) begin
      case (r_opcode)
        OP_R, OP_RW:
          w_single = {r_funct7, r_rs2, r_rs1, r_funct3, r_rd, r_opcode};
        OP_L, OP_JALR:
          w_single = {r_imm[11:0], r_rs1, r_funct3, r_rd, r_opcode};
        OP_RI:
          if (w_shift_f3) begin
            w_single = {r_funct7[6:1], r_imm[5:0], r_rs1, r_funct3, r_rd, r_opcode};
          end else begin
            w_single = {r_imm[11:0], r_rs1, r_funct3, r_rd, r_opcode};
          end
        OP_RIW:
          if (w_shift_f3) begin
            w_single = {r_funct7, r_imm[4:0], r_rs1, r_funct3, r_rd, r_opcode};
          end else begin
            w_single = {r_imm[11:0], r_rs1, r_funct3, r_rd, r_opcode};
          end
        OP_S:
          w_single = {r_imm[11:5], r_rs2, r_rs1, r_funct3, r_imm[4:0], r_opcode};
        OP_B:
          w_single = {r_imm[12], r_imm[10:5], r_rs2, r_rs1, r_funct3,
                      r_imm[4:1], r_imm[11], r_opcode};
        OP_LUI, OP_AUIPC:
          w_single = {r_imm[31:12], r_rd, r_opcode};
        OP_JAL:
          w_single = {r_imm[20], r_imm[10:1], r_imm[11], r_imm[19:12], r_rd, r_opcode};
        default:
          w_single = NOP_WORD;
      endcase
    end
  end

  // Next-state and current word; every state holds until instr_ready.
  always_comb begin
    w_state_next = r_state;
    w_data       = 32'd0;
    w_last       = 1'b0;
    case (r_state)
      IDLE: begin
        if (req_valid) begin
          w_state_next = (req_li && (req_rd != 5'd0)) ? LI_HI : SINGLE;
        end
      end
      SINGLE: begin
        w_data = w_single;
        w_last = 1'b1;
        if (instr_ready) w_state_next = IDLE;
      end
      LI_HI: begin
        w_data = w_u_small ? {w_lo, 5'd0, 3'b000, r_rd, OP_RI}
                           : {w_hi, r_rd, OP_LUI};
        w_last = !w_need_lo && w_fits32;
        if (instr_ready) begin
          if (w_need_lo)      w_state_next = LI_LO;
          else if (!w_fits32) w_state_next = SH1;
          else                w_state_next = IDLE;
        end
      end
      LI_LO: begin
        w_data = {w_lo, r_rd, 3'b000, r_rd, OP_RIW};
        w_last = w_fits32;
        if (instr_ready) w_state_next = w_fits32 ? IDLE : SH1;
      end
      SH1: begin
        w_data = {6'd0, 6'd11, r_rd, 3'b001, r_rd, OP_RI};
        if (instr_ready) w_state_next = AD1;
      end
      AD1: begin
        w_data = {1'b0, r_imm[31:21], r_rd, 3'b000, r_rd, OP_RI};
        if (instr_ready) w_state_next = SH2;
      end
      SH2: begin
        w_data = {6'd0, 6'd11, r_rd, 3'b001, r_rd, OP_RI};
        if (instr_ready) w_state_next = AD2;
      end
      AD2: begin
        w_data = {1'b0, r_imm[20:10], r_rd, 3'b000, r_rd, OP_RI};
        if (instr_ready) w_state_next = SH3;
      end
      SH3: begin
        w_data = {6'd0, 6'd10, r_rd, 3'b001, r_rd, OP_RI};
        if (instr_ready) w_state_next = AD3;
      end
      AD3: begin
        w_data = {2'b00, r_imm[9:0], r_rd, 3'b000, r_rd, OP_RI};
        w_last = 1'b1;
        if (instr_ready) w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  assign req_ready   = (r_state == IDLE);
  assign instr_valid = (r_state != IDLE);
  assign instr_data  = w_data;
  assign instr_last  = w_last;

endmodule

// File: tb/tb_instr_encoder.sv
// Testbench for instr_encoder: directed vector table, hand-written stall and
// reset sequences, then randomized requests checked against a reference model
// that derives expected words directly from the encoding and li-expansion rules.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_li;
  logic [6:0]  req_opcode;
  logic [2:0]  req_funct3;
  logic [6:0]  req_funct7;
  logic [4:0]  req_rd;
  logic [4:0]  req_rs1;
  logic [4:0]  req_rs2;
  logic [63:0] req_imm;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_data;
  logic        instr_last;

  always #5 clk = ~clk;

  instr_encoder dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_li      (req_li),
    .req_opcode  (req_opcode),
    .req_funct3  (req_funct3),
    .req_funct7  (req_funct7),
    .req_rd      (req_rd),
    .req_rs1     (req_rs1),
    .req_rs2     (req_rs2),
    .req_imm     (req_imm),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr_data  (instr_data),
    .instr_last  (instr_last)
  );

  int checks = 0;
  int errors = 0;
  int last_bubbles;
  logic [31:0] exp_q[$];

  typedef struct packed {
    logic             li;
    logic [6:0]       op;
    logic [2:0]       f3;
    logic [6:0]       f7;
    logic [4:0]       rd;
    logic [4:0]       rs1;
    logic [4:0]       rs2;
    logic [63:0]      imm;
    logic [3:0]       n;
    logic [7:0][31:0] w;
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic li, input logic [6:0] op, input logic [2:0] f3,
                              input logic [6:0] f7, input logic [4:0] rd, input logic [4:0] rs1,
                              input logic [4:0] rs2, input logic [63:0] imm, input logic [3:0] n,
                              input logic [31:0] w0, input logic [31:0] w1 = 0,
                              input logic [31:0] w2 = 0, input logic [31:0] w3 = 0,
                              input logic [31:0] w4 = 0, input logic [31:0] w5 = 0,
                              input logic [31:0] w6 = 0);
    vec_t v;
    v = '0;
    v.li = li; v.op = op; v.f3 = f3; v.f7 = f7;
    v.rd = rd; v.rs1 = rs1; v.rs2 = rs2; v.imm = imm; v.n = n;
    v.w[0] = w0; v.w[1] = w1; v.w[2] = w2; v.w[3] = w3;
    v.w[4] = w4; v.w[5] = w5; v.w[6] = w6;
    return v;
  endfunction

  // ---------------- reference model ----------------
  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] m_single(input logic [6:0] op, input logic [2:0] f3,
                                           input logic [6:0] f7, input logic [4:0] rd,
                                           input logic [4:0] rs1, input logic [4:0] rs2,
                                           input logic [63:0] imm);
    logic shamt_form;
    shamt_form = (f3 == 3'd1) || (f3 == 3'd5);
    case (op)
      7'h33, 7'h3B: return {f7, rs2, rs1, f3, rd, op};
      7'h03, 7'h67: return enc_i(imm[11:0], rs1, f3, rd, op);
      7'h13: return shamt_form ? {f7[6:1], imm[5:0], rs1, f3, rd, op}
                               : enc_i(imm[11:0], rs1, f3, rd, op);
      7'h1B: return shamt_form ? {f7, imm[4:0], rs1, f3, rd, op}
                               : enc_i(imm[11:0], rs1, f3, rd, op);
      7'h23: return {imm[11:5], rs2, rs1, f3, imm[4:0], op};
      7'h63: return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
      7'h37, 7'h17: return {imm[31:12], rd, op};
      7'h6F: return {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
      default: return 32'h0000_0013;
    endcase
  endfunction

  // Loads a value known to lie in the signed 32-bit range.
  task automatic m_load32(input logic [4:0] rd, input longint u);
    logic [31:0] u32;
    logic [31:0] sum;
    if (u >= -64'sd2048 && u <= 64'sd2047) begin
      exp_q.push_back(enc_i(u[11:0], 5'd0, 3'd0, rd, 7'h13));
    end else begin
      u32 = u[31:0];
      sum = u32 + 32'h800;
      exp_q.push_back({sum[31:12], rd, 7'h37});
      if (u32[11:0] != 12'd0) exp_q.push_back(enc_i(u32[11:0], rd, 3'd0, rd, 7'h1B));
    end
  endtask

  task automatic m_li(input logic [4:0] rd, input longint v);
    logic [63:0] vb;
    vb = v;
    if (rd == 5'd0) begin
      exp_q.push_back(32'h0000_0013);
    end else if (v >= -64'sd2147483648 && v < 64'sd2147483648) begin
      m_load32(rd, v);
    end else begin
      m_load32(rd, v >>> 32);
      exp_q.push_back(enc_i(12'd11, rd, 3'd1, rd, 7'h13));
      exp_q.push_back(enc_i({1'b0, vb[31:21]}, rd, 3'd0, rd, 7'h13));
      exp_q.push_back(enc_i(12'd11, rd, 3'd1, rd, 7'h13));
      exp_q.push_back(enc_i({1'b0, vb[20:10]}, rd, 3'd0, rd, 7'h13));
      exp_q.push_back(enc_i(12'd10, rd, 3'd1, rd, 7'h13));
      exp_q.push_back(enc_i({2'b00, vb[9:0]}, rd, 3'd0, rd, 7'h13));
    end
  endtask

  // ---------------- drivers ----------------
  // Called at a negedge; returns at the negedge after acceptance.
  task automatic send_req(input logic li, input logic [6:0] op, input logic [2:0] f3,
                          input logic [6:0] f7, input logic [4:0] rd, input logic [4:0] rs1,
                          input logic [4:0] rs2, input logic [63:0] imm);
    int w;
    w = 0;
    while (!req_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    check("req_ready_before", req_ready, 1'b1);
    req_valid = 1'b1; req_li = li; req_opcode = op; req_funct3 = f3; req_funct7 = f7;
    req_rd = rd; req_rs1 = rs1; req_rs2 = rs2; req_imm = imm;
    @(negedge clk);
    req_valid = 1'b0;
    // Scramble the request bus so any field not latched shows up as a wrong word.
    req_li = 1'($urandom); req_opcode = 7'($urandom); req_funct3 = 3'($urandom);
    req_funct7 = 7'($urandom); req_rd = 5'($urandom); req_rs1 = 5'($urandom);
    req_rs2 = 5'($urandom); req_imm = {$urandom, $urandom};
    check("first_word_latency", instr_valid, 1'b1);
  endtask

  task automatic collect(input bit rnd);
    int got;
    int idle;
    int n;
    n = exp_q.size();
    got = 0;
    idle = 0;
    last_bubbles = 0;
    while (got < n) begin
      instr_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (rnd) req_valid = 1'($urandom);
      if (instr_valid) begin
        check("req_ready_busy", req_ready, 1'b0);
        if (instr_ready) begin
          check($sformatf("word%0d", got), instr_data, exp_q[got]);
          check($sformatf("last%0d", got), instr_last, (got == n - 1));
          got++;
        end
      end else begin
        last_bubbles++;
        idle++;
        if (idle > 20) begin
          checks++;
          errors++;
          $display("FAIL word_timeout: got %0d words expected %0d", got, n);
          break;
        end
      end
      @(negedge clk);
    end
    instr_ready = 1'b0;
    req_valid = 1'b0;
    check("req_ready_after", req_ready, 1'b1);
    check("valid_after", instr_valid, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  logic [6:0]  ops [12];
  logic        r_li;
  logic [6:0]  r_op;
  logic [2:0]  r_f3;
  logic [6:0]  r_f7;
  logic [4:0]  r_rd;
  logic [4:0]  r_rs1;
  logic [4:0]  r_rs2;
  logic [63:0] r_imm;
  logic [31:0] r32;
  logic [11:0] s12;
  int          cat;

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_li = 1'b0; req_opcode = '0; req_funct3 = '0;
    req_funct7 = '0; req_rd = '0; req_rs1 = '0; req_rs2 = '0; req_imm = '0;
    instr_ready = 1'b0;

    vecs[0]  = mk(1, 7'h00, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 64'd42, 4'd1, 32'h02A00293);
    vecs[1]  = mk(1, 7'h00, 3'd0, 7'd0, 5'd10, 5'd0, 5'd0, 64'h12345678, 4'd2,
                  32'h12345537, 32'h6785051B);
    vecs[2]  = mk(1, 7'h00, 3'd0, 7'd0, 5'd10, 5'd0, 5'd0, 64'h7FFFFFFF, 4'd2,
                  32'h80000537, 32'hFFF5051B);
    vecs[3]  = mk(1, 7'h00, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 64'h0000_0001_0000_0000, 4'd7,
                  32'h00100093, 32'h00B09093, 32'h00008093, 32'h00B09093,
                  32'h00008093, 32'h00A09093, 32'h00008093);
    vecs[4]  = mk(0, 7'h33, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 64'd0, 4'd1, 32'h002081B3);
    vecs[5]  = mk(0, 7'h63, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 64'hFFFF_FFFF_FFFF_FFFC, 4'd1,
                  32'hFE208EE3);
    vecs[6]  = mk(0, 7'h7F, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 64'd5, 4'd1, 32'h00000013);
    vecs[7]  = mk(1, 7'h33, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 64'h1234_5678_9ABC_DEF0, 4'd1,
                  32'h00000013);
    vecs[8]  = mk(1, 7'h00, 3'd0, 7'd0, 5'd7, 5'd0, 5'd0, 64'hFFFF_FFFF_FFFF_F800, 4'd1,
                  32'h80000393);
    vecs[9]  = mk(1, 7'h00, 3'd0, 7'd0, 5'd6, 5'd0, 5'd0, 64'h1000, 4'd1, 32'h00001337);
    vecs[10] = mk(1, 7'h00, 3'd0, 7'd0, 5'd7, 5'd0, 5'd0, 64'd2048, 4'd2,
                  32'h000013B7, 32'h8003839B);

    ops[0] = 7'h37; ops[1] = 7'h17; ops[2] = 7'h6F; ops[3] = 7'h67;
    ops[4] = 7'h63; ops[5] = 7'h03; ops[6] = 7'h23; ops[7] = 7'h13;
    ops[8] = 7'h1B; ops[9] = 7'h33; ops[10] = 7'h3B; ops[11] = 7'h7F;

    repeat (3) @(negedge clk);
    check("reset_req_ready", req_ready, 1'b1);
    check("reset_instr_valid", instr_valid, 1'b0);
    check("reset_instr_data", instr_data, 32'd0);
    check("reset_instr_last", instr_last, 1'b0);
    reset = 1'b0;
    @(negedge clk);

    // Directed vector table, consumer always ready.
    for (int i = 0; i < 11; i++) begin
      exp_q.delete();
      for (int k = 0; k < int'(vecs[i].n); k++) exp_q.push_back(vecs[i].w[k]);
      send_req(vecs[i].li, vecs[i].op, vecs[i].f3, vecs[i].f7, vecs[i].rd,
               vecs[i].rs1, vecs[i].rs2, vecs[i].imm);
      collect(1'b0);
      check($sformatf("no_bubble_vec%0d", i), last_bubbles, 0);
      $display("vec %0d: li=%0b op=%02h rd=%0d imm=%016h words=%0d", i, vecs[i].li,
               vecs[i].op, vecs[i].rd, vecs[i].imm, vecs[i].n);
    end

    // Stall for three cycles on add x3,x1,x2.
    send_req(1'b0, 7'h33, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 64'd0);
    instr_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("stall_data", instr_data, 32'h002081B3);
      check("stall_valid", instr_valid, 1'b1);
      check("stall_req_ready", req_ready, 1'b0);
      @(negedge clk);
    end
    instr_ready = 1'b1;
    check("stall_release_data", instr_data, 32'h002081B3);
    check("stall_release_last", instr_last, 1'b1);
    @(negedge clk);
    instr_ready = 1'b0;
    check("stall_done_req_ready", req_ready, 1'b1);
    $display("stall: add x3,x1,x2 held 3 cycles");

    // Reset after the third word of a 64-bit li.
    send_req(1'b1, 7'h00, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 64'h0000_0001_0000_0000);
    instr_ready = 1'b1;
    repeat (3) @(negedge clk);
    instr_ready = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midreset_valid", instr_valid, 1'b0);
    check("midreset_req_ready", req_ready, 1'b1);
    @(negedge clk);
    check("midreset_idle_valid", instr_valid, 1'b0);
    exp_q.delete();
    exp_q.push_back(32'h02A00293);
    send_req(1'b1, 7'h00, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 64'd42);
    collect(1'b0);
    $display("reset mid-sequence, then li x5,42");

    // Randomized requests with random backpressure and garbage req_valid.
    for (int t = 0; t < 200; t++) begin
      r_li  = 1'($urandom);
      r_op  = ops[$urandom_range(0, 11)];
      if ($urandom_range(0, 7) == 0) r_op = 7'($urandom);
      r_f3  = 3'($urandom);
      r_f7  = 7'($urandom);
      r_rd  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      r_rs1 = 5'($urandom);
      r_rs2 = 5'($urandom);
      r32   = $urandom;
      s12   = 12'($urandom);
      cat   = $urandom_range(0, 4);
      case (cat)
        0: r_imm = {{52{s12[11]}}, s12};
        1: r_imm = {{32{r32[31]}}, r32};
        2: r_imm = {$urandom, r32};
        3: r_imm = {{32{r32[31]}}, r32[31:12], 12'd0};
        default: r_imm = {{20{s12[11]}}, s12, r32};
      endcase
      exp_q.delete();
      if (r_li) m_li(r_rd, $signed(r_imm));
      else exp_q.push_back(m_single(r_op, r_f3, r_f7, r_rd, r_rs1, r_rs2, r_imm));
      send_req(r_li, r_op, r_f3, r_f7, r_rd, r_rs1, r_rs2, r_imm);
      collect(1'b1);
      $display("rnd %0d: li=%0b op=%02h rd=%0d imm=%016h words=%0d", t, r_li, r_op, r_rd,
               r_imm, exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
